// File: rtl/sat_add_pkg.sv
// Shared types and the width-generic signed saturating-add helper for the shared adder.
// Operands reach sat_add already sign-extended to MAX_W bits; w is the real operand width.
package sat_add_pkg;

  localparam int MAX_W = 64;

  typedef logic signed [MAX_W:0] wide_t;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] sum;
  } sat_res_t;

  function automatic wide_t sat_max(input int w);
    wide_t m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic wide_t sat_min(input int w);
    wide_t m;
    m = '1;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w - 1) m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic sat_res_t sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                       input int w);
    wide_t    s;
    wide_t    hi;
    wide_t    lo;
    sat_res_t r;
    hi    = sat_max(w);
    lo    = sat_min(w);
    s     = $signed({a[MAX_W-1], a}) + $signed({b[MAX_W-1], b});
    r.sat = 1'b0;
    r.sum = s[MAX_W-1:0];
    // Exact sum fits in w+1 bits, so these compares match the top-two-bits overflow test.
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = hi[MAX_W-1:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = lo[MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_add_arbiter_if.sv
// Request/result bundle between the compute lanes (master) and the shared adder (slave).
interface sat_add_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4
);
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i;
  logic                          res_valid_o;
  logic                          res_ready_i;
  logic [DATA_WIDTH-1:0]         res_o;
  logic [ID_WIDTH-1:0]           res_id_o;
  logic                          res_sat_o;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, res_ready_i,
    output req_ready_o, res_valid_o, res_o, res_id_o, res_sat_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_o, res_id_o, res_sat_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ  = 4,
  localparam int ID_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic found;
  int   k;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = ID_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/sat_add_arbiter.sv
// Round-robin shared signed saturating adder with a single registered, id-tagged result stage.
module sat_add_arbiter
  import sat_add_pkg::*;
#(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM_REQ    = 4,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic               clk_i,
  input logic               rst_ni,
  sat_add_arbiter_if.slave  bus
);

  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   ptr_next;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  can_accept;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH:0]   sum;

  function automatic logic [DATA_WIDTH:0] sat_add_dw(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
    sat_res_t r;
    r = sat_add(MAX_W'($signed(a)), MAX_W'($signed(b)), DATA_WIDTH);
    return {r.sat, r.sum[DATA_WIDTH-1:0]};
  endfunction

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid_i),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_accept      = !bus.res_valid_o || bus.res_ready_i;
  // Ready is gated by reset so no requester sees an accept while the block is held in reset.
  assign bus.req_ready_o = (rst_ni && can_accept) ? grant : '0;
  assign transfer        = |(bus.req_valid_i & bus.req_ready_o);

  assign op_a     = bus.req_a_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign op_b     = bus.req_b_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sum      = sat_add_dw(op_a, op_b);
  assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr             <= '0;
      bus.res_valid_o <= 1'b0;
      bus.res_o       <= '0;
      bus.res_id_o    <= '0;
      bus.res_sat_o   <= 1'b0;
    end else if (transfer) begin
      ptr             <= ptr_next;
      bus.res_valid_o <= 1'b1;
      bus.res_o       <= sum[DATA_WIDTH-1:0];
      bus.res_id_o    <= grant_idx;
      bus.res_sat_o   <= sum[DATA_WIDTH];
    end else if (bus.res_ready_i) begin
      bus.res_valid_o <= 1'b0;
    end
  end

endmodule

// File: doc/sat_add_arbiter.md
Name: sat_add_arbiter

Overview:
- Shares one signed saturating-add datapath among NUM_REQ requesters.
- Each requester presents an operand pair (a, b) with a valid/ready handshake.
- A round-robin arbiter picks one requester per cycle. The sum is saturated and registered into a single output stage, tagged with the requester id.
- Sits between the compute lanes and the shared adder resource, giving full throughput of one add per cycle.

Parameters:
- DATA_WIDTH, 16, operand/result width, two's complement, must be >= 2.
- NUM_REQ, 4, number of requesters, must be >= 1.
- ID_WIDTH, (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1, width of the requester id; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NUM_REQ  per-requester operand valid.
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high.
- req_a_i  input  NUM_REQ*DATA_WIDTH  operand a, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_b_i  input  NUM_REQ*DATA_WIDTH  operand b, same packing.
- res_valid_o  output  1  result valid.
- res_ready_i  input  1  downstream accept.
- res_o  output  DATA_WIDTH  saturated signed sum.
- res_id_o  output  ID_WIDTH  index of the requester that produced res_o.
- res_sat_o  output  1  result was clamped.

Behaviour:
- Clock and reset: single clock clk_i. Reset rst_ni is asynchronous assert and active-low; deassertion is synchronous to clk_i at system level.
- Reset values:
  - res_valid_o=0, res_o=0, res_id_o=0, res_sat_o=0.
  - rr pointer=0.
  - req_ready_o=0 during reset.
- Output stage:
  - can_accept = !res_valid_o || res_ready_i.
- Arbitration (combinational, same cycle):
  - Scan req_valid_i starting at index ptr, wrapping modulo NUM_REQ. The first set bit is the grant g.
  - req_ready_o[g] = can_accept. All other ready bits are 0.
  - No valid requests: no ready bits asserted.
- Transfer: occurs when req_valid_i[g] && req_ready_o[g]. On that clock edge:
  - res_o <= sat_sum(a[g], b[g]).
  - res_sat_o <= clamp flag.
  - res_id_o <= g.
  - res_valid_o <= 1.
  - ptr <= (g+1) mod NUM_REQ.
- Pointer hold: ptr is unchanged on any cycle without a transfer, including a stalled grant.
- Drain: if res_valid_o && res_ready_i and there is no transfer, res_valid_o <= 0. res_o, res_id_o and res_sat_o hold their last values.
- Backpressure: while res_valid_o && !res_ready_i, res_o, res_id_o and res_sat_o are stable and no requester is readied.
- Simultaneous drain and transfer: the new result replaces the old one in the same edge. Sustained throughput is 1 result/cycle.
- Latency: 1 cycle from transfer edge to res_valid_o.
- Requester obligation: hold valid and operands stable until ready. Deasserting valid before ready is allowed (request withdrawn, no state change). The block makes no assumption about this.
- Saturating add:
  - Sign-extend both operands to DATA_WIDTH+1 bits, sum s.
  - s[DW:DW-1]==2'b01: result = 0x7FF..F, sat=1.
  - s[DW:DW-1]==2'b10: result = 0x800..0, sat=1.
  - Otherwise: result = s[DW-1:0], sat=0.
- Fairness: a continuously-valid requester is granted within NUM_REQ transfers.
- NUM_REQ=1: ptr stays 0 and the arbiter degenerates to a pass-through handshake.
- Reset mid-operation: an in-flight result is dropped (res_valid_o forced 0 immediately) and ptr returns to 0. Requesters re-present their requests after reset.

Decomposition:
- Shared package sat_add_pkg:
  - function sat_add(a, b) returning {sat, sum} under the rule above, parameterised by width via a localparam-sized wrapper in the module.
  - SAT_MAX/SAT_MIN constant helpers.
- Sub-module rr_arbiter (NUM_REQ):
  - inputs req, ptr; output one-hot grant and encoded index.
  - Purely combinational; the pointer register lives in sat_add_arbiter.
- Saturating add is inline, via the package function.

Test Plan:
1. Reset, then requester 2 presents a=0x0003, b=0x0004 with res_ready_i=1. Required: req_ready_o=4'b0100 the same cycle; next cycle res_o=0x0007, res_id_o=2, res_sat_o=0.
2. Overflow cases:
   - a=0x7000, b=0x2000: res_o=0x7FFF, sat=1.
   - a=0x8000, b=0xFFFF: res_o=0x8000, sat=1.
   - a=0xFFFF, b=0x0001: res_o=0x0000, sat=0.
3. All four requesters valid continuously, res_ready_i=1. Required: res_id_o sequence 0,1,2,3,0,1 on consecutive cycles, with a result every cycle.
4. Result valid with res_ready_i=0 for 3 cycles while requester 1 is valid. Required: res_o/res_id_o stable, req_ready_o=0. Raise res_ready_i: requester 1 is accepted the same cycle, and its result appears next cycle with no bubble.
5. Only requester 3 valid after ptr=0. Required: granted immediately, ptr becomes 0. Then requesters 0 and 3 are both valid: 0 is granted first.
6. Assert rst_ni=0 while res_valid_o=1 and requester 2 is pending. Required: res_valid_o=0 asynchronously and ptr=0. After release, a pending requester 0 wins over 2.
